// File: rtl/alu_issue_ctrl.sv
// Command front-end for the 8-bit registered ALU: buffers commands in a FIFO, issues one
// at a time, waits out the ALU latency and returns an in-order response.
module alu_issue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT    = 1,
    parameter int MUL_EXTRA  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [7:0]                    cmd_a,
    input  logic [7:0]                    cmd_b,
    input  logic [3:0]                    cmd_sel,
    output logic [7:0]                    alu_a,
    output logic [7:0]                    alu_b,
    output logic [3:0]                    alu_sel,
    input  logic [7:0]                    alu_out,
    input  logic                          alu_carry,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [7:0]                    rsp_data,
    output logic                          rsp_carry,
    output logic [3:0]                    rsp_sel,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(ALU_LAT + MUL_EXTRA + 1) + 1;
    localparam logic [WAIT_W-1:0] LAT_BASE = WAIT_W'(ALU_LAT);
    localparam logic [WAIT_W-1:0] LAT_MUL  = WAIT_W'(ALU_LAT + MUL_EXTRA);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [7:0]         fifo_a   [FIFO_DEPTH];
    logic [7:0]         fifo_b   [FIFO_DEPTH];
    logic [3:0]         fifo_sel [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               push;
    logic               pop;

    // Result formatting: {err, carry, data}. Divide-by-zero overrides whatever the ALU produced.
    function automatic logic [9:0] capture(input logic [7:0] b, input logic [3:0] sel,
                                           input logic [7:0] out, input logic carry);
        if (sel == 4'd3 && b == 8'd0)
            return {1'b1, 1'b0, 8'hFF};
        else
            return {1'b0, (sel == 4'd0) ? carry : 1'b0, out};
    endfunction

    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state == S_IDLE) && (count != '0);
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign fifo_count = count;
    assign busy       = (state != S_IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]   <= cmd_a;
            fifo_b[wr_ptr]   <= cmd_b;
            fifo_sel[wr_ptr] <= cmd_sel;
        end
    end

    // cmd_ready comes from the next-cycle count so a full FIFO only reopens after the pop lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_next;
            cmd_ready <= (count_next != FULL_CNT);
        end
    end

    // alu_a/b/sel double as the operand shadow: they only change on a pop in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_sel   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        alu_a    <= fifo_a[rd_ptr];
                        alu_b    <= fifo_b[rd_ptr];
                        alu_sel  <= fifo_sel[rd_ptr];
                        wait_cnt <= (fifo_sel[rd_ptr] == 4'd2) ? LAT_MUL : LAT_BASE;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        {rsp_err, rsp_carry, rsp_data} <= capture(alu_b, alu_sel, alu_out, alu_carry);
                        rsp_sel   <= alu_sel;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, directed timing/value cases, fill and
// randomized traffic checked against an in-order command queue.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_sel;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic [3:0] rsp_sel;
    logic       rsp_err;
    logic       busy;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_sel(rsp_sel), .rsp_err(rsp_err),
        .busy(busy), .fifo_count(fifo_count)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
    } cmd_t;

    cmd_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_rsp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s);
        logic [15:0] p;
        p = {8'd0, a} * {8'd0, b};
        case (s)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return p[7:0];
            4'd3:  return (b == 8'd0) ? 8'h5A : a / b;
            4'd4:  return a << 1;
            4'd5:  return a >> 1;
            4'd6:  return {a[6:0], a[7]};
            4'd7:  return {a[0], a[7:1]};
            4'd8:  return a & b;
            4'd9:  return a | b;
            4'd10: return a ^ b;
            4'd11: return ~(a | b);
            4'd12: return ~(a & b);
            4'd13: return ~(a ^ b);
            4'd14: return (a > b) ? 8'd1 : 8'd0;
            default: return (a == b) ? 8'd1 : 8'd0;
        endcase
    endfunction

    function automatic logic add_carry(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8];
    endfunction

    // Registered ALU with one cycle of latency
    always @(posedge clk) begin
        alu_out   <= alu_fn(alu_a, alu_b, alu_sel);
        alu_carry <= add_carry(alu_a, alu_b);
    end

    // Scoreboard: handshakes are observed at the negedge preceding the edge that takes them
    logic       hold_v = 1'b0;
    logic [7:0] h_data;
    logic       h_carry;
    logic [3:0] h_sel;
    logic       h_err;

    always @(negedge clk) begin
        cmd_t       c;
        logic [7:0] ed;
        logic       ec;
        logic       ee;
        if (!rst_n) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v && rsp_valid) begin
                chk("hold_data",  32'(rsp_data),  32'(h_data));
                chk("hold_carry", 32'(rsp_carry), 32'(h_carry));
                chk("hold_sel",   32'(rsp_sel),   32'(h_sel));
                chk("hold_err",   32'(rsp_err),   32'(h_err));
            end
            hold_v  = rsp_valid && !rsp_ready;
            h_data  = rsp_data;
            h_carry = rsp_carry;
            h_sel   = rsp_sel;
            h_err   = rsp_err;
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("rsp_extra", 32'(q.size()), 32'd1);
                end else begin
                    c = q.pop_front();
                    if (c.sel == 4'd3 && c.b == 8'd0) begin
                        ed = 8'hFF; ec = 1'b0; ee = 1'b1;
                    end else begin
                        ed = alu_fn(c.a, c.b, c.sel);
                        ec = (c.sel == 4'd0) ? add_carry(c.a, c.b) : 1'b0;
                        ee = 1'b0;
                    end
                    chk("rsp_data",  32'(rsp_data),  32'(ed));
                    chk("rsp_carry", 32'(rsp_carry), 32'(ec));
                    chk("rsp_sel",   32'(rsp_sel),   32'(c.sel));
                    chk("rsp_err",   32'(rsp_err),   32'(ee));
                    n_rsp++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                c.a = cmd_a; c.b = cmd_b; c.sel = cmd_sel;
                q.push_back(c);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        logic ok;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = s;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_ready", 32'(ok), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Counts negedges after the accepting edge until rsp_valid shows; add expects 4, mul 5
    task automatic wait_rsp(input string tag, input int lat, input logic [7:0] d,
                            input logic c, input logic e);
        int n;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
        end
        chk({tag, "_lat"},   32'(n),         32'(lat));
        chk({tag, "_data"},  32'(rsp_data),  32'(d));
        chk({tag, "_carry"}, 32'(rsp_carry), 32'(c));
        chk({tag, "_err"},   32'(rsp_err),   32'(e));
        @(posedge clk); #1;
    endtask

    task automatic fill_step(inout int k, inout int n_acc);
        logic acc;
        @(negedge clk);
        acc = cmd_valid && cmd_ready;
        @(posedge clk); #1;
        if (acc) begin
            n_acc++;
            k++;
            if (k >= 8) begin
                cmd_valid = 1'b0;
            end else begin
                cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_sel = 4'(k);
            end
        end
    endtask

    initial begin
        int   k;
        int   n_acc;
        int   r0;
        int   n;
        int   sent;
        logic acc;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_cmd_ready",  32'(cmd_ready),  32'd1);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_alu",        32'({alu_a, alu_b, alu_sel}), 32'd0);
        @(posedge clk); #1;

        send(8'h6A, 8'h3B, 4'd0); wait_rsp("add",   4, 8'hA5, 1'b0, 1'b0);
        send(8'hFF, 8'h02, 4'd0); wait_rsp("addc",  4, 8'h01, 1'b1, 1'b0);
        send(8'h6A, 8'h3B, 4'd2); wait_rsp("mul",   5, 8'h6E, 1'b0, 1'b0);
        send(8'h10, 8'h00, 4'd3); wait_rsp("div0",  4, 8'hFF, 1'b0, 1'b1);
        send(8'h6A, 8'h3B, 4'd3); wait_rsp("div",   4, 8'h01, 1'b0, 1'b0);

        // Reset while an add is waiting on the ALU
        send(8'h6A, 8'h3B, 4'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("arst_alu",        32'({alu_a, alu_b, alu_sel}), 32'd0);
        chk("arst_fifo_count", 32'(fifo_count), 32'd0);
        chk("arst_cmd_ready",  32'(cmd_ready),  32'd1);
        chk("arst_busy",       32'(busy),       32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("arst_no_rsp", 32'(n), 32'd0);
        @(posedge clk); #1;

        // Fill with the consumer stalled, then release
        rsp_ready = 1'b0;
        r0 = n_rsp; k = 0; n_acc = 0;
        cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_sel = 4'd0; cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) fill_step(k, n_acc);
        chk("fill_accepted", 32'(n_acc),      32'd5);
        chk("fill_ready",    32'(cmd_ready),  32'd0);
        chk("fill_count",    32'(fifo_count), 32'd4);
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && k < 8; i++) fill_step(k, n_acc);
        for (int i = 0; i < 100 && (q.size() != 0 || rsp_valid); i++) @(negedge clk);
        chk("fill_rsps", 32'(n_rsp - r0), 32'd8);
        @(posedge clk); #1;

        // Randomized traffic with random consumer backpressure
        sent = 0; cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 6000 && sent < 300; cyc++) begin
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            if (acc || !cmd_valid) begin
                cmd_valid = ($urandom_range(0, 9) < 6);
                cmd_a     = 8'($urandom);
                cmd_b     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                cmd_sel   = 4'($urandom_range(0, 15));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        cmd_valid = 1'b0;
        chk("rand_sent", 32'(sent), 32'd300);
        rsp_ready = 1'b1;
        for (int i = 0; i < 200 && (q.size() != 0 || rsp_valid); i++) @(negedge clk);
        chk("drain_left", 32'(q.size()), 32'd0);
        @(negedge clk);
        chk("drain_busy",      32'(busy),      32'd0);
        chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
